// File: rtl/imem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// imem_port_arbiter_if
// Bundles the CPU fetch, debug/loader and instruction-memory signals that
// meet at the instruction-memory arbiter.
//   master : the environment (fetch stage, debug loader and memory together).
//            It drives the requests and mem_rdata, and it observes the grants,
//            the responses and the memory command.
//   slave  : the arbiter itself.
// Parameters: AW word-address width, DW data width.
// ---------------------------------------------------------------------------
interface imem_port_arbiter_if #(
   parameter int AW = 30,
   parameter int DW = 32
);
   // CPU fetch port
   logic          cpu_req_valid;
   logic [AW-1:0] cpu_addr;
   logic          cpu_stall;
   logic          cpu_rvalid;
   logic [DW-1:0] cpu_rdata;
   // Debug / loader port
   logic          dbg_req_valid;
   logic          dbg_we;
   logic [AW-1:0] dbg_addr;
   logic [DW-1:0] dbg_wdata;
   logic          dbg_req_ready;
   logic          dbg_rvalid;
   logic [DW-1:0] dbg_rdata;
   // Instruction memory port
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   modport master (
      output cpu_req_valid, cpu_addr,
      input  cpu_stall, cpu_rvalid, cpu_rdata,
      output dbg_req_valid, dbg_we, dbg_addr, dbg_wdata,
      input  dbg_req_ready, dbg_rvalid, dbg_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );

   modport slave (
      input  cpu_req_valid, cpu_addr,
      output cpu_stall, cpu_rvalid, cpu_rdata,
      input  dbg_req_valid, dbg_we, dbg_addr, dbg_wdata,
      output dbg_req_ready, dbg_rvalid, dbg_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );
endinterface

// File: rtl/imem_port_arbiter.sv
// ---------------------------------------------------------------------------
// imem_port_arbiter
// Shares a single-port, synchronous-read instruction memory between the CPU
// fetch stage and a debug/loader port. The CPU normally wins. A saturating
// starvation counter forces a pending debug request through after it has
// lost STARVE_MAX consecutive cycles. Read data goes back to the requester
// that issued the access one cycle earlier. The CPU keeps seeing its last
// fetched instruction while it is stalled.
// Ports:
//   clk    : single clock, every state update on posedge
//   rst_n  : synchronous active-low reset. While it is low, no grant is given.
//   bus    : imem_port_arbiter_if.slave, which carries the CPU, debug and
//            memory signals
// Parameters: AW address width, DW data width, STARVE_MAX (1..255)
// ---------------------------------------------------------------------------
module imem_port_arbiter #(
   parameter int AW         = 30,
   parameter int DW         = 32,
   parameter int STARVE_MAX = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   imem_port_arbiter_if.slave  bus
);

   localparam logic [7:0] STARVE_MAX_C = 8'(STARVE_MAX);

   logic [7:0]    starve_cnt_r;
   logic          cpu_rvalid_r;
   logic          dbg_rvalid_r;
   logic [DW-1:0] cpu_hold_r;
   logic          cpu_grant_s;
   logic          dbg_grant_s;

   // Grant decision: debug wins when the CPU is idle or debug has starved long enough.
   always_comb begin
      dbg_grant_s = 1'b0;
      cpu_grant_s = 1'b0;
      if (!rst_n) begin
         dbg_grant_s = 1'b0;
         cpu_grant_s = 1'b0;
      end else begin
         dbg_grant_s = bus.dbg_req_valid &
                       (~bus.cpu_req_valid | (starve_cnt_r == STARVE_MAX_C));
         cpu_grant_s = bus.cpu_req_valid & ~dbg_grant_s;
      end
   end

   // Memory command mux and requester-facing handshake status.
   always_comb begin
      bus.mem_en        = 1'b0;
      bus.mem_we        = 1'b0;
      bus.mem_addr      = {AW{1'b0}};
      bus.mem_wdata     = bus.dbg_wdata;
      bus.cpu_stall     = bus.cpu_req_valid & ~cpu_grant_s;
      bus.dbg_req_ready = dbg_grant_s;
      if (dbg_grant_s) begin
         bus.mem_en   = 1'b1;
         bus.mem_we   = bus.dbg_we;
         bus.mem_addr = bus.dbg_addr;
      end else if (cpu_grant_s) begin
         bus.mem_en   = 1'b1;
         bus.mem_we   = 1'b0;
         bus.mem_addr = bus.cpu_addr;
      end else begin
         bus.mem_en   = 1'b0;
         bus.mem_we   = 1'b0;
         bus.mem_addr = {AW{1'b0}};
      end
   end

   // Read-data steering. The CPU falls back to the held instruction when no fetch returns this cycle.
   always_comb begin
      bus.cpu_rvalid = cpu_rvalid_r;
      bus.dbg_rvalid = dbg_rvalid_r;
      bus.cpu_rdata  = cpu_hold_r;
      bus.dbg_rdata  = {DW{1'b0}};
      if (cpu_rvalid_r) begin
         bus.cpu_rdata = bus.mem_rdata;
      end else begin
         bus.cpu_rdata = cpu_hold_r;
      end
      if (dbg_rvalid_r) begin
         bus.dbg_rdata = bus.mem_rdata;
      end else begin
         bus.dbg_rdata = {DW{1'b0}};
      end
   end

   // Starvation counter, in-flight response flags and the CPU instruction hold register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         starve_cnt_r <= 8'd0;
         cpu_rvalid_r <= 1'b0;
         dbg_rvalid_r <= 1'b0;
         cpu_hold_r   <= {DW{1'b0}};
      end else begin
         // The counter only counts consecutive cycles in which a debug request is pending and loses.
         if (dbg_grant_s || !bus.dbg_req_valid) begin
            starve_cnt_r <= 8'd0;
         end else if (starve_cnt_r != STARVE_MAX_C) begin
            starve_cnt_r <= starve_cnt_r + 8'd1;
         end else begin
            starve_cnt_r <= starve_cnt_r;
         end
         cpu_rvalid_r <= cpu_grant_s;
         // Debug writes complete silently, so only debug reads produce a response.
         dbg_rvalid_r <= dbg_grant_s & ~bus.dbg_we;
         if (cpu_rvalid_r) begin
            cpu_hold_r <= bus.mem_rdata;
         end else begin
            cpu_hold_r <= cpu_hold_r;
         end
      end
   end

endmodule

// File: doc/imem_port_arbiter.md
# imem_port_arbiter

Shares the single-port, synchronous-read instruction memory between the CPU fetch stage and a debug/loader port (read and write). The CPU has priority. A saturating starvation counter guarantees the debug port a slot. Read data is routed back to the winning requester one cycle after issue, and the CPU sees its last fetched instruction held stable while it is stalled. The block sits between the fetch stage, the debug/UART loader and the instruction memory.

## Interface
- AW, 30, word-address width
- DW, 32, data width
- STARVE_MAX, 8, cycles a pending debug request may lose before it is forced through (legal range 1..255)

- clk  in  1  single clock, all state updates on posedge
- rst_n  in  1  synchronous, active-low reset, sampled on posedge clk
- cpu_req_valid  in  1  fetch request this cycle
- cpu_addr  in  AW  fetch word address
- cpu_stall  out  1  fetch request not granted this cycle; CPU must hold cpu_addr
- cpu_rvalid  out  1  cpu_rdata is the result of the fetch issued last cycle
- cpu_rdata  out  DW  instruction to fetch stage
- dbg_req_valid  in  1  debug access request
- dbg_we  in  1  1 = write, 0 = read
- dbg_addr  in  AW  debug word address
- dbg_wdata  in  DW  debug write data
- dbg_req_ready  out  1  debug request accepted this cycle
- dbg_rvalid  out  1  dbg_rdata is the result of the debug read issued last cycle
- dbg_rdata  out  DW  debug read data
- mem_en  out  1  memory access this cycle
- mem_we  out  1  memory write strobe
- mem_addr  out  AW  memory address, registered by memory on posedge
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid the cycle after the address is sampled

## Operation
- At most one access is issued per cycle. cpu_grant and dbg_grant are combinational and mutually exclusive.
- Priority:
  - dbg_grant = dbg_req_valid & (~cpu_req_valid | starve_cnt == STARVE_MAX)
  - cpu_grant = cpu_req_valid & ~dbg_grant
- cpu_stall = cpu_req_valid & ~cpu_grant. dbg_req_ready = dbg_grant.
- Memory mux:
  - On a grant, mem_en=1 and mem_addr is taken from the grantee. mem_we = dbg_grant & dbg_we. mem_wdata = dbg_wdata.
  - With no grant, mem_en=0, mem_we=0, mem_addr=0.
- starve_cnt (8 bit):
  - Cleared on any dbg_grant, or when dbg_req_valid=0.
  - Otherwise incremented, saturating at STARVE_MAX.
- Issue tracking, registered:
  - cpu_rvalid <= cpu_grant
  - dbg_rvalid <= dbg_grant & ~dbg_we
  - Debug writes return no response.
- CPU data path:
  - cpu_rdata = cpu_rvalid ? mem_rdata : cpu_hold.
  - cpu_hold <= mem_rdata whenever cpu_rvalid=1.
  - The fetch stage therefore sees a stable instruction through stalls, including cycles where the memory is serving the debug port.
- dbg_rdata = mem_rdata when dbg_rvalid=1, else 0.
- Write/read address conflicts are memory semantics; the arbiter does not forward data.

## Timing
- Reset (rst_n=0 at posedge):
  - starve_cnt=0, cpu_rvalid=0, dbg_rvalid=0, cpu_hold=0.
  - While rst_n is low, both grants are forced to 0. This gives mem_en=0, mem_addr=0, dbg_req_ready=0, cpu_stall=cpu_req_valid.
- Read latency: request granted in cycle N, so the memory samples the address at the end of N. Data and rvalid are presented in cycle N+1.
- Back-to-back CPU fetches sustain one instruction per cycle when there is no debug traffic.
- With CPU continuously requesting and debug pending from cycle N:
  - The debug request loses N..N+STARVE_MAX-1 and is granted in cycle N+STARVE_MAX.
  - CPU stalls exactly that one cycle; the counter then restarts from 0.
- Debug request withdrawn before grant: counter clears next cycle, no memory access, no response.
- Reset asserted mid-access: the in-flight rvalid is cleared at that posedge and the response is dropped.
- Debug handshake: dbg_* must stay stable while dbg_req_valid=1 and dbg_req_ready=0.

## Test plan
- CPU only, addresses 0,1,2,3 on consecutive cycles, memory returns addr+0x100 -> cpu_stall=0 throughout. cpu_rvalid=1 from cycle 1, cpu_rdata 0x100,0x101,0x102,0x103. dbg_rvalid never 1.
- CPU idle, debug write 0x12345678 to addr 0x10 -> mem_en=mem_we=1 in the same cycle, dbg_req_ready=1, no dbg_rvalid. A debug read of 0x10 the next cycle gives dbg_rvalid=1 and dbg_rdata=0x12345678 one cycle later.
- STARVE_MAX=8, CPU requesting every cycle, debug read pending from cycle 0 -> dbg_req_ready first 1 in cycle 8. cpu_stall=1 only in cycle 8. dbg_rvalid=1 in cycle 9. A second pending debug request is next granted in cycle 17.
- CPU fetch of 0x24170000 in cycle 0, then the CPU is stalled during a debug read in cycle 1 returning 0xDEADBEEF -> cpu_rdata stays 0x24170000 in cycle 2, and dbg_rdata=0xDEADBEEF in cycle 2.
- rst_n low in the cycle after a CPU grant -> cpu_rvalid=0 next cycle, cpu_rdata=0, mem_addr=0, mem_en=0 while reset is held. Normal fetch resumes the cycle after rst_n returns high.
- Debug pending 5 cycles (STARVE_MAX=8), withdrawn for 1 cycle, re-asserted -> the counter restarts, so the grant comes 8 cycles after re-assertion, not 3.
